// File: rtl/fft256_pkg.sv
// fft256_pkg
// Shared constants and helpers for the 256-point FFT (16x16) datapath.
//   FFT_N / FFT_LOG2N : transform size and index width
//   ROT_LATENCY       : ED-cycle latency of twiddle_rotator256
//   twiddle_exp       : twiddle exponent (row*col) mod 256 for a stream index
//   twiddle_q         : quantized cos/sin value of W256^e in Q1.(w-1)
//   round_sat         : round-half-up, arithmetic shift, saturate to w bits
package fft256_pkg;

  localparam int FFT_N       = 256;
  localparam int FFT_LOG2N   = 8;
  localparam int ROT_LATENCY = 4;

  localparam real TWO_PI = 6.283185307179586;

  // row = idx[3:0] (bin of the first 16-point stage), col = idx[7:4] (batch).
  function automatic logic [FFT_LOG2N-1:0] twiddle_exp(input logic [FFT_LOG2N-1:0] idx);
    return {4'b0000, idx[3:0]} * {4'b0000, idx[7:4]};
  endfunction

  // round(x) with halves away from zero, done explicitly so the table does
  // not depend on a tool's real-to-integer conversion rule.
  function automatic int round_real(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(0.5 - x);
  endfunction

  // Full scale is 2^(w-1)-1 so that cos(0) stays representable.
  function automatic int twiddle_q(input int e, input int w, input bit want_sin);
    real ang;
    real amp;
    ang = TWO_PI * real'(e) / real'(FFT_N);
    amp = real'((1 << (w - 1)) - 1);
    if (want_sin) return round_real($sin(ang) * amp);
    else          return round_real($cos(ang) * amp);
  endfunction

  function automatic logic signed [63:0] round_sat(input logic signed [63:0] x,
                                                   input int frac,
                                                   input int w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (x + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (r > hi)      return hi;
    else if (r < lo) return lo;
    else             return r;
  endfunction

endpackage

// File: rtl/twiddle_rom256.sv
// twiddle_rom256
// 256-entry cos/sin table of W256^e, registered read (loads only when ED=1).
// Ports:
//   CLK, RST     clock, synchronous active-high reset (clears the read register)
//   ED           read enable
//   addr         twiddle exponent e
//   cos_q, sin_q quantized cos/sin of 2*pi*e/256, signed Q1.(nw-1)
module twiddle_rom256
  import fft256_pkg::*;
#(
  parameter int nw = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ED,
  input  logic [FFT_LOG2N-1:0]  addr,
  output logic signed [nw-1:0]  cos_q,
  output logic signed [nw-1:0]  sin_q
);

  logic [2*nw-1:0] rom_tab [FFT_N];

  for (genvar g = 0; g < FFT_N; g++) begin : g_tab
    assign rom_tab[g] = {nw'(twiddle_q(g, nw, 1'b0)), nw'(twiddle_q(g, nw, 1'b1))};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cos_q <= '0;
      sin_q <= '0;
    end else if (ED) begin
      {cos_q, sin_q} <= rom_tab[addr];
    end
  end

endmodule

// File: rtl/twiddle_rotator256.sv
// twiddle_rotator256
// Inter-stage twiddle multiplier of the 16x16 256-point FFT: each streamed
// sample with index ct is multiplied by W256^((ct[3:0]*ct[7:4]) mod 256).
// Build option: define TWIDDLE_ROTATOR_IFFT_EN to use the conjugate twiddle
// (inverse transform); default is the forward transform W = C - jS.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   ED         enable strobe, everything holds when 0
//   START      frame restart (effective only with ED=1, sample discarded)
//   DIR, DII   input sample, signed nb bits
//   DOR, DOI   rotated sample, signed nb bits, 4 ED cycles after acceptance
//   RDY        pulse while index 0 of an armed frame is on DOR/DOI
module twiddle_rotator256
  import fft256_pkg::*;
#(
  parameter int nb = 16,
  parameter int nw = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ED,
  input  logic                 START,
  input  logic signed [nb-1:0] DIR,
  input  logic signed [nb-1:0] DII,
  output logic signed [nb-1:0] DOR,
  output logic signed [nb-1:0] DOI,
  output logic                 RDY
);

  localparam int PW = nb + nw;
  localparam int SW = PW + 1;

  logic [7:0]           ct;
  logic                 armed;
  logic                 start_ed;
  logic [7:0]           rom_addr;
  logic signed [nw-1:0] cos_q;
  logic signed [nw-1:0] sin_q;

  logic signed [nb-1:0] a1, b1;
  logic                 byp1, t1;
  logic signed [PW-1:0] p_ac, p_bs, p_bc, p_as;
  logic                 t2;
  logic signed [SW-1:0] sum_re, sum_im;
  logic                 t3;
  logic                 t4;

  assign start_ed = ED & START;
  assign rom_addr = twiddle_exp(ct);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ct    <= '0;
      armed <= 1'b0;
    end else if (start_ed) begin
      ct    <= '0;
      armed <= 1'b1;
    end else if (ED) begin
      ct <= ct + 8'd1;
    end
  end

  // The ROM read register sits alongside stage 1, so C/S line up with a1/b1.
  twiddle_rom256 #(.nw(nw)) u_rom (
    .CLK   (CLK),
    .RST   (RST),
    .ED    (ED),
    .addr  (rom_addr),
    .cos_q (cos_q),
    .sin_q (sin_q)
  );

  // t1..t4 mark the index-0 sample; a START wipes every tag so an aborted
  // frame can never raise RDY, while its data still drains.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a1   <= '0;
      b1   <= '0;
      byp1 <= 1'b0;
      t1   <= 1'b0;
    end else if (ED) begin
      a1   <= DIR;
      b1   <= DII;
      byp1 <= (rom_addr == 8'd0);
      t1   <= ~START & (ct == 8'd0);
    end
  end

  // e=0 must be exact: C=2^(nw-1)-1 would lose gain, so a/b are injected
  // pre-scaled by 2^(nw-1) and the rounding stage returns them unchanged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_ac <= '0;
      p_bs <= '0;
      p_bc <= '0;
      p_as <= '0;
      t2   <= 1'b0;
    end else if (ED) begin
      if (byp1) begin
        p_ac <= PW'(a1) <<< (nw - 1);
        p_bs <= '0;
        p_bc <= PW'(b1) <<< (nw - 1);
        p_as <= '0;
      end else begin
        p_ac <= PW'(a1) * PW'(cos_q);
        p_bs <= PW'(b1) * PW'(sin_q);
        p_bc <= PW'(b1) * PW'(cos_q);
        p_as <= PW'(a1) * PW'(sin_q);
      end
      t2 <= t1 & ~START;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sum_re <= '0;
      sum_im <= '0;
      t3     <= 1'b0;
    end else if (ED) begin
`ifdef TWIDDLE_ROTATOR_IFFT_EN
      sum_re <= SW'(p_ac) - SW'(p_bs);
      sum_im <= SW'(p_bc) + SW'(p_as);
`else
      sum_re <= SW'(p_ac) + SW'(p_bs);
      sum_im <= SW'(p_bc) - SW'(p_as);
`endif
      t3 <= t2 & ~START;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DOR <= '0;
      DOI <= '0;
      t4  <= 1'b0;
    end else if (ED) begin
      DOR <= nb'(round_sat(64'(sum_re), nw - 1, nb));
      DOI <= nb'(round_sat(64'(sum_im), nw - 1, nb));
      t4  <= t3 & ~START;
    end
  end

  assign RDY = t4 & armed & ED;

endmodule

// File: tb/tb_twiddle_rotator256.sv
// tb_twiddle_rotator256
// Directed bench for twiddle_rotator256 (nb=nw=16). Expected outputs are
// hand-computed per index; a 4-deep tag/value pipeline in the bench tracks
// where each expected value and index-0 tag should be on every cycle.
// Honours TWIDDLE_ROTATOR_IFFT_EN for the rotated-value expectations.
module tb_twiddle_rotator256;

  logic               CLK = 1'b0;
  logic               RST, ED, START;
  logic signed [15:0] DIR, DII;
  logic signed [15:0] DOR, DOI;
  logic               RDY;

  int total = 0;
  int bad   = 0;

  bit       m_kn [4];
  int       m_re [4];
  int       m_im [4];
  bit       m_t0 [4];
  bit [7:0] m_ct    = '0;
  bit       m_armed = 1'b0;
  int       ed_cnt  = 0;
  int       acc0    = -100;

  twiddle_rotator256 #(.nb(16), .nw(16)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .ED    (ED),
    .START (START),
    .DIR   (DIR),
    .DII   (DII),
    .DOR   (DOR),
    .DOI   (DOI),
    .RDY   (RDY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp_v, $time);
    end
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Stimulus and expected result for stream index i (kn=0: value not checked).
  task automatic vec(input int i, output int dr, output int di, output bit kn,
                     output int er, output int ei);
    dr = rnd16(); di = rnd16(); kn = 1'b0; er = 0; ei = 0;
    if (i < 16) begin
      dr = 1000; di = 0; kn = 1'b1; er = 1000; ei = 0;
    end else if (i % 16 == 0) begin
      dr = i * 100 - 12000; di = -i; kn = 1'b1; er = dr; ei = di;
    end else if (i == 'h11) begin
      dr = 16384; di = 0; kn = 1'b1;
`ifdef TWIDDLE_ROTATOR_IFFT_EN
      er = 16379; ei = 402;
`else
      er = 16379; ei = -402;
`endif
    end else if (i == 'h88) begin
      dr = 1000; di = 2000; kn = 1'b1;
`ifdef TWIDDLE_ROTATOR_IFFT_EN
      er = -2000; ei = 1000;
`else
      er = 2000; ei = -1000;
`endif
    end else if (i == 'h48) begin
      dr = 32767; di = 32767; kn = 1'b1;
`ifdef TWIDDLE_ROTATOR_IFFT_EN
      er = 0; ei = 32767;
`else
      er = 32767; ei = 0;
`endif
    end else if (i == 'h84) begin
      dr = -32768; di = -32768; kn = 1'b1;
`ifdef TWIDDLE_ROTATOR_IFFT_EN
      er = 0; ei = -32768;
`else
      er = -32768; ei = 0;
`endif
    end
  endtask

  // One clock cycle: drive at negedge, check just after, advance model at posedge.
  task automatic cyc(input bit rst_v, input bit ed, input bit st, input int dr,
                     input int di, input bit kn, input int er, input int ei);
    @(negedge CLK);
    RST = rst_v; ED = ed; START = st;
    DIR = 16'(dr); DII = 16'(di);
    #1;
    if (ed && !rst_v) ed_cnt++;
    if (m_kn[3]) begin
      chk("dor", int'(DOR), m_re[3]);
      chk("doi", int'(DOI), m_im[3]);
    end
    chk("rdy", int'(RDY), int'(m_t0[3] && m_armed && ed));
    if (RDY === 1'b1) chk("rdy_lat", ed_cnt - acc0, 4);
    if (ed && !st && !rst_v && m_ct == 8'd0) acc0 = ed_cnt;
    @(posedge CLK);
    if (rst_v) begin
      for (int j = 0; j < 4; j++) begin
        m_kn[j] = 1'b1; m_re[j] = 0; m_im[j] = 0; m_t0[j] = 1'b0;
      end
      m_ct = '0; m_armed = 1'b0;
    end else if (ed) begin
      for (int j = 3; j > 0; j--) begin
        m_kn[j] = m_kn[j-1]; m_re[j] = m_re[j-1];
        m_im[j] = m_im[j-1]; m_t0[j] = m_t0[j-1];
      end
      m_kn[0] = kn && !st; m_re[0] = er; m_im[0] = ei;
      m_t0[0] = !st && (m_ct == 8'd0);
      if (st) begin
        for (int j = 0; j < 4; j++) m_t0[j] = 1'b0;
        m_ct = '0; m_armed = 1'b1;
      end else begin
        m_ct = m_ct + 8'd1;
      end
    end
  endtask

  task automatic run_idx(input int i);
    int dr, di, er, ei;
    bit kn;
    vec(i, dr, di, kn, er, ei);
    cyc(1'b0, 1'b1, 1'b0, dr, di, kn, er, ei);
  endtask

  task automatic do_start(input bit ed_v);
    cyc(1'b0, ed_v, 1'b1, rnd16(), rnd16(), 1'b0, 0, 0);
  endtask

  initial begin
    int  k;
    bit  restarted;
    RST = 1'b1; ED = 1'b0; START = 1'b0; DIR = '0; DII = '0;
    for (int j = 0; j < 4; j++) begin
      m_kn[j] = 1'b0; m_re[j] = 0; m_im[j] = 0; m_t0[j] = 1'b0;
    end

    // Reset, with ED and START asserted during the later reset cycles.
    cyc(1'b1, 1'b0, 1'b0, rnd16(), rnd16(), 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 1'b1, rnd16(), rnd16(), 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 1'b1, rnd16(), rnd16(), 1'b0, 0, 0);
    // Unarmed streaming: index 0 passes through but must not raise RDY.
    for (int n = 0; n < 20; n++) cyc(1'b0, 1'b1, 1'b0, rnd16(), rnd16(), 1'b0, 0, 0);

    // Full frame plus wrap into the next one (second RDY 256 ED cycles later).
    do_start(1'b1);
    for (int n = 0; n < 264; n++) run_idx(n % 256);

    // START while index 0 is still in flight: its tag must be dropped.
    do_start(1'b1);
    run_idx(0);
    run_idx(1);
    do_start(1'b1);
    for (int n = 0; n < 12; n++) run_idx(n);

    // ED toggling 1,0,1,0; START with ED=0 is ignored; restart at index 100.
    do_start(1'b1);
    k = 0;
    restarted = 1'b0;
    while (!(restarted && k > 20)) begin
      if (!restarted && k == 100) begin
        do_start(1'b1);
        restarted = 1'b1;
        k = 0;
      end else begin
        run_idx(k);
        k++;
      end
      cyc(1'b0, 1'b0, (k == 50 && !restarted), rnd16(), rnd16(), 1'b0, 0, 0);
    end

    for (int n = 0; n < 6; n++) cyc(1'b0, 1'b1, 1'b0, rnd16(), rnd16(), 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
